// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================
// pipeline_pkg : shared encodings for the PC sequencer
// Rev 1.0
// ============================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'b00,
    SEQ_HALTED = 2'b01,
    SEQ_STEP   = 2'b10
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_INC    = 2'd3
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================
// pc_next_mux : priority next-PC select with wrapping increment
// Rev 1.0
// ============================================================
module pc_next_mux
  import pipeline_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc_cur,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stall,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt_instr,
  input  logic                hold_all,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                adv
);

  localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  pc_sel_e sel;

  always_comb begin
    sel = SEL_INC;
    // Branch is the older instruction, so it beats a stall caused by younger ones.
    if (branch_taken)    sel = SEL_BRANCH;
    else if (stall)      sel = SEL_HOLD;
    else if (jump)       sel = SEL_JUMP;
    else if (halt_instr) sel = SEL_HOLD;
    if (hold_all)        sel = SEL_HOLD;
  end

  always_comb begin
    pc_next = pc_cur;
    case (sel)
      SEL_BRANCH: pc_next = branch_target;
      SEL_HOLD:   pc_next = pc_cur;
      SEL_JUMP:   pc_next = jump_target;
      default:    pc_next = pc_cur + c_pc_one;
    endcase
  end

  assign adv = (sel != SEL_HOLD);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================
// pc_sequencer : next-PC generation, run/halt/step FSM, advance counter
// Rev 1.0
// ============================================================
module pc_sequencer
  import pipeline_pkg::*;
#(
  parameter int                  PC_WIDTH  = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  pc_cur,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 halt_instr,
  input  logic                 dbg_halt_req,
  input  logic                 dbg_step_req,
  input  logic                 dbg_resume_req,
  output logic [PC_WIDTH-1:0]  pc_next,
  output logic                 pc_adv,
  output logic                 running,
  output logic                 halted,
  output logic                 step_done,
  output logic [CNT_WIDTH-1:0] adv_count
);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] adv_count_q, adv_count_d;
  logic                 step_done_q, step_done_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;

  logic [PC_WIDTH-1:0]  mux_next;
  logic                 mux_adv;
  logic                 step_complete;

  pc_next_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_mux (
    .pc_cur        (pc_cur),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_instr    (halt_instr),
    .hold_all      (state_q == SEQ_HALTED),
    .pc_next       (mux_next),
    .adv           (mux_adv)
  );

  // Reset forces RESET_PC so the PC register loads it on any edge while held.
  assign pc_next = rst_n ? mux_next : RESET_PC;
  assign pc_adv  = rst_n & mux_adv;

  // A HALT instruction ends a step unless a stall is still holding it back.
  assign step_complete = pc_adv | (halt_instr & ~stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_RUN;
      adv_count_q <= '0;
      step_done_q <= 1'b0;
      running_q   <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      adv_count_q <= adv_count_d;
      step_done_q <= step_done_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_RUN: begin
        if (dbg_halt_req || halt_instr) state_d = SEQ_HALTED;
      end
      SEQ_HALTED: begin
        if (dbg_resume_req)    state_d = SEQ_RUN;
        else if (dbg_step_req) state_d = SEQ_STEP;
      end
      SEQ_STEP: begin
        if (dbg_resume_req)     state_d = SEQ_RUN;
        else if (step_complete) state_d = SEQ_HALTED;
      end
      default: state_d = SEQ_RUN;
    endcase
  end

  always_comb begin
    running_d   = (state_d == SEQ_RUN);
    halted_d    = (state_d == SEQ_HALTED);
    step_done_d = (state_q == SEQ_STEP) && !dbg_resume_req && step_complete;
    adv_count_d = adv_count_q + {{(CNT_WIDTH-1){1'b0}}, pc_adv};
  end

  assign running   = running_q;
  assign halted    = halted_q;
  assign step_done = step_done_q;
  assign adv_count = adv_count_q;

endmodule
`default_nettype wire
